decode_stage: RTL

Parametrised, registered instruction-decode pipeline stage between fetch and register-read. Accepts raw instruction words over a valid/ready handshake and splits them into opcode, register, shift-amount, reserved and immediate fields. A 2-entry skid buffer keeps in_ready a pure register output. Adds flush, back-pressure, R/I/NOP classification and a decoded-instruction counter.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/decode_stage_field_extract.sv | 82 ++++++++
 rtl/decode_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - default field widths for the 32-bit instruction format
//   - ins_class_t: NOP / R-type / I-type classification
//   - decode_bundle_t: decoded field bundle at default widths
// Optional feature macro: DECODE_ILLEGAL_EN adds the 'illegal' bundle flag.
package decode_pkg;

  localparam int DEF_INS_W     = 32;
  localparam int DEF_OPC_W     = 6;
  localparam int DEF_REG_W     = 5;
  localparam int DEF_IMM_W     = 32;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RSV_W     = DEF_INS_W - DEF_OPC_W - 4*DEF_REG_W;
  localparam int DEF_IMM_SRC_W = DEF_INS_W - DEF_OPC_W - 2*DEF_REG_W;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_R,
    CLS_I
  } ins_class_t;

  typedef struct packed {
    logic [DEF_OPC_W-1:0] opcode;
    logic [DEF_REG_W-1:0] reg1;
    logic [DEF_REG_W-1:0] reg2;
    logic [DEF_REG_W-1:0] reg3;
    logic [DEF_REG_W-1:0] sr_amount;
    logic [DEF_RSV_W-1:0] reserved;
    logic [DEF_IMM_W-1:0] imm;
    logic                 is_itype;
    logic                 is_nop;
`ifdef DECODE_ILLEGAL_EN
    logic                 illegal;
`endif
  } decode_bundle_t;

endpackage

// File: rtl/decode_stage_field_extract.sv
// field_extract: purely combinational split of a raw instruction word into
// its decoded bundle fields.
// Ports:
//   i_ins                  raw instruction word
//   o_opcode/o_reg1/o_reg2 always passed through
//   o_reg3/o_sr_amount/o_reserved  R-type only, else 0
//   o_imm                  extended immediate, I-type only, else 0
//   o_is_itype/o_is_nop    classification flags
//   o_illegal              opcode hit in ILLEGAL_MASK (DECODE_ILLEGAL_EN only)
// Optional feature macro: DECODE_ILLEGAL_EN.
module field_extract
  import decode_pkg::*;
#(
  parameter int INS_W = DEF_INS_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int REG_W = DEF_REG_W,
  parameter int IMM_W = DEF_IMM_W,
`ifdef DECODE_ILLEGAL_EN
  parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0,
`endif
  parameter int SIGN_EXT = 1
) (
  input  logic [INS_W-1:0]                 i_ins,
  output logic [OPC_W-1:0]                 o_opcode,
  output logic [REG_W-1:0]                 o_reg1,
  output logic [REG_W-1:0]                 o_reg2,
  output logic [REG_W-1:0]                 o_reg3,
  output logic [REG_W-1:0]                 o_sr_amount,
  output logic [INS_W-OPC_W-4*REG_W-1:0]   o_reserved,
  output logic [IMM_W-1:0]                 o_imm,
  output logic                             o_is_itype,
`ifdef DECODE_ILLEGAL_EN
  output logic                             o_illegal,
`endif
  output logic                             o_is_nop
);

  localparam int RSV_W     = INS_W - OPC_W - 4*REG_W;
  localparam int IMM_SRC_W = INS_W - OPC_W - 2*REG_W;
  localparam int ITYPE_BIT = INS_W - 2;

  ins_class_t             w_cls;
  logic [IMM_SRC_W-1:0]   w_imm_src;
  logic [IMM_W-1:0]       w_imm_ext;

  assign w_cls     = (i_ins == '0) ? CLS_NOP : (i_ins[ITYPE_BIT] ? CLS_I : CLS_R);
  assign w_imm_src = i_ins[IMM_SRC_W-1:0];

  // Fill pattern is shifted above the source bits, so it also works when
  // IMM_W == IMM_SRC_W (shift clears everything, no zero-width replication).
  assign w_imm_ext = ({IMM_W{(SIGN_EXT != 0) && w_imm_src[IMM_SRC_W-1]}} << IMM_SRC_W)
                   | IMM_W'(w_imm_src);

  always_comb begin
    o_opcode    = i_ins[INS_W-1 -: OPC_W];
    o_reg1      = i_ins[INS_W-OPC_W-1 -: REG_W];
    o_reg2      = i_ins[INS_W-OPC_W-REG_W-1 -: REG_W];
    o_reg3      = '0;
    o_sr_amount = '0;
    o_reserved  = '0;
    o_imm       = '0;
    o_is_itype  = 1'b0;
    o_is_nop    = 1'b0;
    case (w_cls)
      CLS_NOP: o_is_nop = 1'b1;
      CLS_I: begin
        o_is_itype = 1'b1;
        o_imm      = w_imm_ext;
      end
      default: begin
        o_reg3      = i_ins[INS_W-OPC_W-2*REG_W-1 -: REG_W];
        o_sr_amount = i_ins[INS_W-OPC_W-3*REG_W-1 -: REG_W];
        o_reserved  = i_ins[RSV_W-1:0];
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  assign o_illegal = ILLEGAL_MASK[o_opcode];
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a 2-slot skid
// buffer (main, skid). The word is decoded on entry; the slots hold the
// decoded bundle. in_ready is the inverse of the skid-valid flop, so it
// never depends combinationally on out_ready.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 drop both slots next cycle
//   in_valid/in_ready/in_ins   fetch-side handshake and raw word
//   out_valid/out_ready   downstream handshake
//   out_*                 decoded bundle fields (from the main slot)
//   out_illegal           opcode flagged by ILLEGAL_MASK (DECODE_ILLEGAL_EN only)
//   decoded_count         bundles delivered, wraps, survives flush
// Optional feature macro: DECODE_ILLEGAL_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INS_W = DEF_INS_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int REG_W = DEF_REG_W,
  parameter int IMM_W = DEF_IMM_W,
  parameter int CNT_W = DEF_CNT_W,
`ifdef DECODE_ILLEGAL_EN
  parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0,
`endif
  parameter int SIGN_EXT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INS_W-1:0]               in_ins,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPC_W-1:0]               out_opcode,
  output logic [REG_W-1:0]               out_reg1,
  output logic [REG_W-1:0]               out_reg2,
  output logic [REG_W-1:0]               out_reg3,
  output logic [REG_W-1:0]               out_sr_amount,
  output logic [INS_W-OPC_W-4*REG_W-1:0] out_reserved,
  output logic [IMM_W-1:0]               out_imm,
  output logic                           out_is_itype,
  output logic                           out_is_nop,
`ifdef DECODE_ILLEGAL_EN
  output logic                           out_illegal,
`endif
  output logic [CNT_W-1:0]               decoded_count
);

  localparam int RSV_W  = INS_W - OPC_W - 4*REG_W;
  localparam int BASE_W = OPC_W + 4*REG_W + RSV_W + IMM_W + 2;
`ifdef DECODE_ILLEGAL_EN
  localparam int BND_W  = BASE_W + 1;
`else
  localparam int BND_W  = BASE_W;
`endif

  logic [OPC_W-1:0] w_opcode;
  logic [REG_W-1:0] w_reg1, w_reg2, w_reg3, w_sr_amount;
  logic [RSV_W-1:0] w_reserved;
  logic [IMM_W-1:0] w_imm;
  logic             w_is_itype, w_is_nop;
  logic [BND_W-1:0] w_dec;
  logic             w_acc, w_drain;

  logic             r_main_valid, r_skid_valid;
  logic [BND_W-1:0] r_main_bnd, r_skid_bnd;
  logic [CNT_W-1:0] r_cnt;

`ifdef DECODE_ILLEGAL_EN
  logic w_illegal;
`endif

  field_extract #(
    .INS_W        (INS_W),
    .OPC_W        (OPC_W),
    .REG_W        (REG_W),
    .IMM_W        (IMM_W),
`ifdef DECODE_ILLEGAL_EN
    .ILLEGAL_MASK (ILLEGAL_MASK),
`endif
    .SIGN_EXT     (SIGN_EXT)
  ) u_field_extract (
    .i_ins       (in_ins),
    .o_opcode    (w_opcode),
    .o_reg1      (w_reg1),
    .o_reg2      (w_reg2),
    .o_reg3      (w_reg3),
    .o_sr_amount (w_sr_amount),
    .o_reserved  (w_reserved),
    .o_imm       (w_imm),
    .o_is_itype  (w_is_itype),
`ifdef DECODE_ILLEGAL_EN
    .o_illegal   (w_illegal),
`endif
    .o_is_nop    (w_is_nop)
  );

`ifdef DECODE_ILLEGAL_EN
  assign w_dec = {w_opcode, w_reg1, w_reg2, w_reg3, w_sr_amount, w_reserved,
                  w_imm, w_is_itype, w_is_nop, w_illegal};
  assign {out_opcode, out_reg1, out_reg2, out_reg3, out_sr_amount, out_reserved,
          out_imm, out_is_itype, out_is_nop, out_illegal} = r_main_bnd;
`else
  assign w_dec = {w_opcode, w_reg1, w_reg2, w_reg3, w_sr_amount, w_reserved,
                  w_imm, w_is_itype, w_is_nop};
  assign {out_opcode, out_reg1, out_reg2, out_reg3, out_sr_amount, out_reserved,
          out_imm, out_is_itype, out_is_nop} = r_main_bnd;
`endif

  assign w_acc   = in_valid && !r_skid_valid;
  assign w_drain = r_main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_bnd   <= '0;
      r_skid_bnd   <= '0;
      r_cnt        <= '0;
    end else begin
      if (w_drain) r_cnt <= r_cnt + CNT_W'(1);
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_drain) begin
        // Skid full implies in_ready was low, so no accept competes here.
        if (r_skid_valid) begin
          r_main_bnd   <= r_skid_bnd;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_acc;
          if (w_acc) r_main_bnd <= w_dec;
        end
      end else if (w_acc) begin
        r_skid_bnd   <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready      = !r_skid_valid;
  assign out_valid     = r_main_valid;
  assign decoded_count = r_cnt;

endmodule
